// File: rtl/fft_bfp_scale_ctrl.sv
// Block-floating-point scaling scheduler for an 8-point FFT: scans each stage's input
// samples for guard-bit headroom, selects the sar_n path per stage and tracks the block exponent.
module fft_bfp_scale_ctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned POINTS = 8,
    parameter int unsigned STAGES = 3,
    parameter int unsigned EXP_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [(2**N)-1:0]    s_data,
    output logic                 s_ready,
    output logic                 busy,
    output logic [1:0]           stage_idx,
    output logic                 shft_en,
    output logic                 stage_done,
    output logic                 done,
    output logic [EXP_W-1:0]     exponent
);

    localparam int unsigned W     = 2**N;
    localparam int unsigned CNT_W = $clog2(POINTS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               need;
    logic               shft_q;

    logic               accept;
    logic               guard_miss;
    logic               last_sample;
    logic               last_stage;
    logic [EXP_W-1:0]   exp_next;
    logic               unused_low_bits;

    // A sample lacks a guard bit when its two MSBs differ.
    assign guard_miss      = s_data[W-1] ^ s_data[W-2];
    assign unused_low_bits = ^s_data[W-3:0];

    assign accept      = s_valid & s_ready;
    assign last_sample = (cnt == CNT_W'(POINTS - 1));
    assign last_stage  = (stage_idx == 2'(STAGES - 1));

    // Saturating block-exponent increment.
    assign exp_next = (need && (exponent != {EXP_W{1'b1}})) ? exponent + EXP_W'(1) : exponent;

    // The datapath samples the select on stage_done, so expose the fresh decision during DECIDE.
    assign shft_en = (state == ST_DECIDE) ? need : shft_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            need       <= 1'b0;
            shft_q     <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            stage_idx  <= '0;
            stage_done <= 1'b0;
            done       <= 1'b0;
            exponent   <= '0;
        end else if (abort) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            need       <= 1'b0;
            shft_q     <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            stage_idx  <= '0;
            stage_done <= 1'b0;
            done       <= 1'b0;
            exponent   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SCAN;
                        busy      <= 1'b1;
                        s_ready   <= 1'b1;
                        stage_idx <= '0;
                        exponent  <= '0;
                        cnt       <= '0;
                        need      <= 1'b0;
                        shft_q    <= 1'b0;
                    end
                end

                ST_SCAN: begin
                    if (accept) begin
                        cnt  <= cnt + CNT_W'(1);
                        need <= need | guard_miss;
                        if (last_sample) begin
                            state      <= ST_DECIDE;
                            s_ready    <= 1'b0;
                            stage_done <= 1'b1;
                        end
                    end
                end

                ST_DECIDE: begin
                    stage_done <= 1'b0;
                    shft_q     <= need;
                    exponent   <= exp_next;
                    cnt        <= '0;
                    need       <= 1'b0;
                    if (last_stage) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= ST_SCAN;
                        stage_idx <= stage_idx + 2'd1;
                        s_ready   <= 1'b1;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
